// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential signed multiplier
// controller (mult_ctrl) and its RUN-cycle step counter (mult_step_cnt).
package mult_pkg;

    localparam int OP_W          = 8;
    localparam int RES_W         = 16;
    localparam int TIMEOUT_STEPS = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Re-apply the operand sign to the unsigned magnitude product (modulo 2^RES_W).
    function automatic logic [RES_W-1:0] apply_sign(input logic sgn,
                                                    input logic [RES_W-1:0] mag);
        return sgn ? (~mag + RES_W'(1)) : mag;
    endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// mult_step_cnt: 4-bit clear/increment counter with a terminal flag.
// Used by mult_ctrl to bound the number of RUN cycles when MULT_CTRL_TIMEOUT_EN
// is defined. term_o is high once TIMEOUT_STEPS-1 increments have been seen, so
// the cycle in which it is high is the TIMEOUT_STEPS-th counted cycle.
module mult_step_cnt
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam logic [3:0] TERM_CNT = 4'(TIMEOUT_STEPS - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == TERM_CNT);

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: controller for a shift/add signed 8x8 multiplier. Operands are
// captured on start, the external datapath works on magnitudes, and the sign is
// re-applied to the magnitude product in FIX.
// Optional feature: define MULT_CTRL_TIMEOUT_EN to abort RUN after
// TIMEOUT_STEPS consecutive non-zero cycles with error=1 and result=0.
module mult_ctrl
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  mp,
    input  logic [OP_W-1:0]  mc,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             error,
    output logic [OP_W-1:0]  dp_mp,
    output logic [OP_W-1:0]  dp_mc,
    output logic             dp_clr,
    output logic             dp_load,
    output logic             dp_enable,
    output logic             dp_psel,
    input  logic             dp_b0,
    input  logic             dp_zero,
    input  logic [RES_W-1:0] dp_product
);

    state_e           state_q, state_d;
    logic             sgn_q, sgn_d;
    logic [OP_W-1:0]  dp_mp_q, dp_mp_d;
    logic [OP_W-1:0]  dp_mc_q, dp_mc_d;
    logic [RES_W-1:0] result_q, result_d;

`ifdef MULT_CTRL_TIMEOUT_EN
    logic error_q, error_d;
    logic step_term;

    // Counts RUN cycles in which the datapath still has work; cleared outside RUN.
    mult_step_cnt u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != RUN),
        .inc_i  ((state_q == RUN) && !dp_zero),
        .term_o (step_term)
    );

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Next-state, datapath strobes and register updates for the control FSM.
    always_comb begin
        state_d   = state_q;
        sgn_d     = sgn_q;
        dp_mp_d   = dp_mp_q;
        dp_mc_d   = dp_mc_q;
        result_d  = result_q;
`ifdef MULT_CTRL_TIMEOUT_EN
        error_d   = error_q;
`endif
        busy      = 1'b1;
        done      = 1'b0;
        dp_clr    = 1'b0;
        dp_load   = 1'b0;
        dp_enable = 1'b0;
        dp_psel   = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    dp_mp_d = mp;
                    dp_mc_d = mc;
                    sgn_d   = mp[OP_W-1] ^ mc[OP_W-1];
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                dp_clr  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                dp_load = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // Strobes follow the datapath flags in the same cycle.
                dp_enable = !dp_zero;
                dp_psel   = dp_b0 & !dp_zero;
                if (dp_zero) begin
                    state_d = FIX;
                end
`ifdef MULT_CTRL_TIMEOUT_EN
                else if (step_term) begin
                    state_d  = DONE;
                    result_d = '0;
                    error_d  = 1'b1;
                end
`endif
            end
            FIX: begin
                result_d = apply_sign(sgn_q, dp_product);
`ifdef MULT_CTRL_TIMEOUT_EN
                error_d  = 1'b0;
`endif
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-data registers; reset returns everything to zero/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sgn_q    <= 1'b0;
            dp_mp_q  <= '0;
            dp_mc_q  <= '0;
            result_q <= '0;
`ifdef MULT_CTRL_TIMEOUT_EN
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sgn_q    <= sgn_d;
            dp_mp_q  <= dp_mp_d;
            dp_mc_q  <= dp_mc_d;
            result_q <= result_d;
`ifdef MULT_CTRL_TIMEOUT_EN
            error_q  <= error_d;
`endif
        end
    end

    assign dp_mp  = dp_mp_q;
    assign dp_mc  = dp_mc_q;
    assign result = result_q;

endmodule
